// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - issue stage: register file, flags, scoreboard, bypass, ALU operand drive
// Optional build macro R0_ZERO_EN: r0 is hardwired to zero and never tracked as pending.
module operand_fetch #(
  parameter int WIDTH       = 32,
  parameter int OPCODE      = 4,
  parameter int REGS_CODING = 3,
  parameter int FLAGS       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPCODE-1:0]      in_opcode,
  input  logic [REGS_CODING-1:0] in_dest,
  input  logic [REGS_CODING-1:0] in_src1,
  input  logic [REGS_CODING-1:0] in_src2,
  input  logic [WIDTH-1:0]       in_imm,
  input  logic                   in_use_imm,
  input  logic                   in_wr_dest,
  input  logic                   in_wr_flags,
  input  logic                   in_use_cin,
  output logic                   alu_en,
  output logic [OPCODE-1:0]      alu_opcode,
  output logic [REGS_CODING-1:0] alu_dest,
  output logic [WIDTH-1:0]       alu_op1,
  output logic [WIDTH-1:0]       alu_op2,
  output logic                   alu_cin,
  input  logic                   wb_en,
  input  logic [REGS_CODING-1:0] wb_dest,
  input  logic [WIDTH-1:0]       wb_result,
  input  logic                   wb_flags_en,
  input  logic [FLAGS-1:0]       wb_flags,
  output logic [FLAGS-1:0]       flags
);

  localparam int NREGS = 1 << REGS_CODING;
  localparam int CARRY = 0;

  logic [WIDTH-1:0]       rf_q [NREGS];
  logic [WIDTH-1:0]       rf_d [NREGS];
  logic [FLAGS-1:0]       flags_q, flags_d;
  logic [NREGS-1:0]       pend_q, pend_d;
  logic                   pend_f_q, pend_f_d;

  logic                   alu_en_q, alu_en_d;
  logic [OPCODE-1:0]      alu_opcode_q, alu_opcode_d;
  logic [REGS_CODING-1:0] alu_dest_q, alu_dest_d;
  logic [WIDTH-1:0]       alu_op1_q, alu_op1_d;
  logic [WIDTH-1:0]       alu_op2_q, alu_op2_d;
  logic                   alu_cin_q, alu_cin_d;

  logic [NREGS-1:0]       clr;
  logic [NREGS-1:0]       pend_eff;
  logic                   pend_f_eff;
  logic                   hazard;
  logic                   accept;
  logic                   wb_writable;
  logic                   dest_trackable;
  logic [WIDTH-1:0]       rd_op1, rd_op2;
  logic                   rd_cin;

`ifdef R0_ZERO_EN
  assign wb_writable    = (wb_dest != '0);
  assign dest_trackable = (in_dest != '0);
`else
  assign wb_writable    = 1'b1;
  assign dest_trackable = 1'b1;
`endif

  // A write-back landing this cycle retires its pending bit before the hazard check.
  always_comb begin
    clr = '0;
    if (wb_en) clr[wb_dest] = 1'b1;
  end

  assign pend_eff   = pend_q & ~clr;
  assign pend_f_eff = pend_f_q & ~wb_flags_en;

  assign hazard = pend_eff[in_src1]
                | (~in_use_imm & pend_eff[in_src2])
                | (in_wr_dest & pend_eff[in_dest])
                | ((in_use_cin | in_wr_flags) & pend_f_eff);

  assign in_ready = ~in_valid | ~hazard;
  assign accept   = in_valid & in_ready;

  always_comb begin
    rd_op1 = (wb_en && wb_dest == in_src1) ? wb_result : rf_q[in_src1];
    rd_op2 = (wb_en && wb_dest == in_src2) ? wb_result : rf_q[in_src2];
`ifdef R0_ZERO_EN
    if (in_src1 == '0) rd_op1 = '0;
    if (in_src2 == '0) rd_op2 = '0;
`endif
    if (in_use_imm) rd_op2 = in_imm;
    rd_cin = 1'b0;
    if (in_use_cin) rd_cin = wb_flags_en ? wb_flags[CARRY] : flags_q[CARRY];
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_en && wb_writable) rf_d[wb_dest] = wb_result;
    flags_d = wb_flags_en ? wb_flags : flags_q;
  end

  // Set on accept is applied after clear so a same-index set/clear leaves the bit set.
  always_comb begin
    pend_d = pend_eff;
    if (accept && in_wr_dest && dest_trackable) pend_d[in_dest] = 1'b1;
    pend_f_d = pend_f_eff | (accept & in_wr_flags);
  end

  always_comb begin
    alu_en_d     = accept;
    alu_opcode_d = alu_opcode_q;
    alu_dest_d   = alu_dest_q;
    alu_op1_d    = alu_op1_q;
    alu_op2_d    = alu_op2_q;
    alu_cin_d    = alu_cin_q;
    if (accept) begin
      alu_opcode_d = in_opcode;
      alu_dest_d   = in_dest;
      alu_op1_d    = rd_op1;
      alu_op2_d    = rd_op2;
      alu_cin_d    = rd_cin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      flags_q      <= '0;
      pend_q       <= '0;
      pend_f_q     <= 1'b0;
      alu_en_q     <= 1'b0;
      alu_opcode_q <= '0;
      alu_dest_q   <= '0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      alu_cin_q    <= 1'b0;
    end else begin
      rf_q         <= rf_d;
      flags_q      <= flags_d;
      pend_q       <= pend_d;
      pend_f_q     <= pend_f_d;
      alu_en_q     <= alu_en_d;
      alu_opcode_q <= alu_opcode_d;
      alu_dest_q   <= alu_dest_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
      alu_cin_q    <= alu_cin_d;
    end
  end

  assign alu_en     = alu_en_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_dest   = alu_dest_q;
  assign alu_op1    = alu_op1_q;
  assign alu_op2    = alu_op2_q;
  assign alu_cin    = alu_cin_q;
  assign flags      = flags_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed self-checking bench for operand_fetch
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [2:0]  in_dest;
  logic [2:0]  in_src1;
  logic [2:0]  in_src2;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic        in_wr_dest;
  logic        in_wr_flags;
  logic        in_use_cin;
  logic        alu_en;
  logic [3:0]  alu_opcode;
  logic [2:0]  alu_dest;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic        alu_cin;
  logic        wb_en;
  logic [2:0]  wb_dest;
  logic [31:0] wb_result;
  logic        wb_flags_en;
  logic [3:0]  wb_flags;
  logic [3:0]  flags;

  int n_cmp = 0;
  int n_err = 0;

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_dest(in_dest), .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_wr_dest(in_wr_dest), .in_wr_flags(in_wr_flags),
    .in_use_cin(in_use_cin),
    .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_dest(alu_dest),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_cin(alu_cin),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_result(wb_result),
    .wb_flags_en(wb_flags_en), .wb_flags(wb_flags), .flags(flags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 0; in_opcode = 0; in_dest = 0; in_src1 = 0; in_src2 = 0;
    in_imm = 0; in_use_imm = 0; in_wr_dest = 0; in_wr_flags = 0; in_use_cin = 0;
  endtask

  task automatic idle_wb();
    wb_en = 0; wb_dest = 0; wb_result = 0; wb_flags_en = 0; wb_flags = 0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s1,
                       input logic [2:0] s2, input logic [31:0] imm, input logic ui,
                       input logic wd, input logic wf, input logic uc);
    in_valid = 1; in_opcode = op; in_dest = d; in_src1 = s1; in_src2 = s2;
    in_imm = imm; in_use_imm = ui; in_wr_dest = wd; in_wr_flags = wf; in_use_cin = uc;
  endtask

  initial begin
    rst_n = 0;
    idle_in();
    idle_wb();
    tick(); tick();
    chk("rst_alu_en", {31'd0, alu_en}, 32'd0);
    chk("rst_alu_op1", alu_op1, 32'd0);
    chk("rst_alu_op2", alu_op2, 32'd0);
    chk("rst_alu_opcode", {28'd0, alu_opcode}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1;
    tick();

    // write-back then read
    wb_en = 1; wb_dest = 3; wb_result = 32'h0000_1234;
    tick();
    idle_wb();
    issue(4'd5, 3'd1, 3'd3, 3'd1, 32'd0, 0, 0, 0, 0);
    #1 chk("t2_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("t2_alu_en", {31'd0, alu_en}, 32'd1);
    chk("t2_op1", alu_op1, 32'h0000_1234);
    chk("t2_op2", alu_op2, 32'd0);
    chk("t2_opcode", {28'd0, alu_opcode}, 32'd5);
    idle_in();
    tick();
    chk("t2_alu_en_pulse", {31'd0, alu_en}, 32'd0);
    chk("t2_op1_hold", alu_op1, 32'h0000_1234);

    // same-cycle bypass
    issue(4'd2, 3'd0, 3'd6, 3'd3, 32'd0, 0, 0, 0, 0);
    wb_en = 1; wb_dest = 6; wb_result = 32'hA5A5_A5A5;
    tick();
    idle_wb(); idle_in();
    chk("byp_op1", alu_op1, 32'hA5A5_A5A5);
    chk("byp_op2", alu_op2, 32'h0000_1234);

    // RAW stall on r2 released by write-back
    issue(4'd1, 3'd2, 3'd0, 3'd0, 32'd0, 0, 1, 0, 0);
    tick();
    chk("t3_dest", {29'd0, alu_dest}, 32'd2);
    issue(4'd3, 3'd0, 3'd2, 3'd0, 32'd0, 0, 0, 0, 0);
    #1 chk("t3_stall", {31'd0, in_ready}, 32'd0);
    tick();
    chk("t3_no_issue", {31'd0, alu_en}, 32'd0);
    wb_en = 1; wb_dest = 2; wb_result = 32'hCAFE_0001;
    #1 chk("t3_release", {31'd0, in_ready}, 32'd1);
    tick();
    idle_wb(); idle_in();
    chk("t3_alu_en", {31'd0, alu_en}, 32'd1);
    chk("t3_op1", alu_op1, 32'hCAFE_0001);

    // immediate ignores pending src2
    issue(4'd1, 3'd5, 3'd0, 3'd0, 32'd0, 0, 1, 0, 0);
    tick();
    issue(4'd4, 3'd0, 3'd0, 3'd5, 32'h0000_007F, 1, 0, 0, 0);
    #1 chk("t4_ready_imm", {31'd0, in_ready}, 32'd1);
    tick();
    chk("t4_op2", alu_op2, 32'h0000_007F);
    issue(4'd4, 3'd0, 3'd0, 3'd5, 32'd0, 0, 0, 0, 0);
    #1 chk("t4_stall_src2", {31'd0, in_ready}, 32'd0);
    idle_in();
    #1 chk("t4_ready_novalid", {31'd0, in_ready}, 32'd1);

    // flags scoreboard and carry bypass
    issue(4'd6, 3'd0, 3'd0, 3'd0, 32'd0, 0, 0, 1, 0);
    tick();
    issue(4'd7, 3'd0, 3'd0, 3'd0, 32'd0, 0, 0, 0, 1);
    #1 chk("t5_cin_stall", {31'd0, in_ready}, 32'd0);
    wb_flags_en = 1; wb_flags = 4'b0001;
    #1 chk("t5_cin_release", {31'd0, in_ready}, 32'd1);
    tick();
    idle_wb();
    chk("t5_cin", {31'd0, alu_cin}, 32'd1);
    chk("t5_flags", {28'd0, flags}, 32'd1);
    issue(4'd7, 3'd0, 3'd0, 3'd0, 32'd0, 0, 0, 0, 0);
    tick();
    chk("t5_cin_unused", {31'd0, alu_cin}, 32'd0);

    // WAW stall and set-wins-over-clear on r4
    issue(4'd1, 3'd4, 3'd0, 3'd0, 32'd0, 0, 1, 0, 0);
    tick();
    issue(4'd1, 3'd4, 3'd0, 3'd0, 32'd0, 0, 1, 0, 0);
    #1 chk("t5_waw_stall", {31'd0, in_ready}, 32'd0);
    wb_en = 1; wb_dest = 4; wb_result = 32'h0000_0044;
    #1 chk("t5_waw_release", {31'd0, in_ready}, 32'd1);
    tick();
    idle_wb();
    issue(4'd1, 3'd0, 3'd4, 3'd0, 32'd0, 0, 0, 0, 0);
    #1 chk("set_wins", {31'd0, in_ready}, 32'd0);
    idle_in();

    // r0 write then read
    wb_en = 1; wb_dest = 0; wb_result = 32'hFFFF_FFFF;
    tick();
    idle_wb();
    issue(4'd2, 3'd1, 3'd0, 3'd0, 32'd0, 0, 0, 0, 0);
    tick();
    idle_in();
`ifdef R0_ZERO_EN
    chk("t6_r0", alu_op1, 32'd0);
`else
    chk("t6_r0", alu_op1, 32'hFFFF_FFFF);
`endif

    // reset mid-stream
    issue(4'd9, 3'd2, 3'd0, 3'd0, 32'd0, 0, 1, 0, 0);
    tick();
    idle_in();
    chk("t1_alu_en_pre", {31'd0, alu_en}, 32'd1);
    rst_n = 0;
    #1;
    chk("t1_alu_en", {31'd0, alu_en}, 32'd0);
    chk("t1_flags", {28'd0, flags}, 32'd0);
    chk("t1_opcode", {28'd0, alu_opcode}, 32'd0);
    tick();
    rst_n = 1;
    issue(4'd3, 3'd0, 3'd2, 3'd0, 32'd0, 0, 0, 0, 0);
    #1 chk("t1_ready", {31'd0, in_ready}, 32'd1);
    tick();
    idle_in();
    chk("t1_issue", {31'd0, alu_en}, 32'd1);
    chk("t1_op1", alu_op1, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
